// File: rtl/sobel_edge_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_detector_pkg
// Description : Shared pixel/gradient types and image defaults for the Sobel
//               edge-detection stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_edge_detector_pkg;

    localparam int PIX_W      = 4;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_THRESH = 24;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic signed [6:0] grad_t;

    // Absolute value of a gradient; inputs never reach -64, so 7 bits hold it.
    function automatic logic [6:0] abs7(input grad_t g);
        return g[6] ? $unsigned(-g) : $unsigned(g);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_edge_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_detector_if
// Description : Pixel-in / edge-out streaming bundle for the Sobel stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_edge_detector_if;
    import sobel_edge_detector_pkg::*;

    pixel_t     pixel_in;
    logic       in_valid;
    logic       sof;
    logic [3:0] edge_mag;
    logic       edge_bit;
    logic       out_valid;

    modport master (output pixel_in, in_valid, sof,
                    input  edge_mag, edge_bit, out_valid);
    modport slave  (input  pixel_in, in_valid, sof,
                    output edge_mag, edge_bit, out_valid);
endinterface
`default_nettype wire

// File: rtl/sobel_edge_detector_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_detector_window_3x3
// Description : Raster position counters, two line buffers and a 3x3 tap
//               array. The window is centred on (row-1, col-1) of the beat
//               that completes it; o_border flags incomplete/wrapped windows.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_edge_detector_window_3x3
    import sobel_edge_detector_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  wire logic clk,
    input  wire logic rst,
    input  pixel_t    i_pixel_in,
    input  wire logic i_in_valid,
    input  wire logic i_sof,
    output pixel_t    o_taps [3][3],   // [0]=top .. [2]=bottom, [x][0]=oldest
    output logic      o_win_valid,
    output logic      o_border
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] r_col, w_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row, w_row_nxt;
    pixel_t           r_line_old [IMG_W];
    pixel_t           r_line_new [IMG_W];
    pixel_t           w_old_rd, w_new_rd;
    pixel_t           r_taps [3][3];
    logic             r_win_valid, r_border;

    // Position of the current beat (sof forces (0,0)) and the next position
    always_comb begin
        w_col     = i_sof ? '0 : r_col;
        w_row     = i_sof ? '0 : r_row;
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == COL_W'(IMG_W - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_W'(IMG_H - 1)) ? '0 : w_row + 1'b1;
        end
    end

    assign w_old_rd = r_line_old[w_col];
    assign w_new_rd = r_line_new[w_col];

    // Line buffers: the previous row ages into the older buffer column by column
    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            r_line_old[w_col] <= w_new_rd;
            r_line_new[w_col] <= i_pixel_in;
        end
    end

    // Counters, tap shift registers and border flag, advancing on each beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_border    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    r_taps[r][k] <= '0;
                end
            end
        end else begin
            r_win_valid <= i_in_valid;
            if (i_in_valid) begin
                r_col    <= w_col_nxt;
                r_row    <= w_row_nxt;
                r_border <= (w_row < ROW_W'(2)) || (w_col < COL_W'(2));
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 2; k++) begin
                        r_taps[r][k] <= r_taps[r][k+1];
                    end
                end
                r_taps[0][2] <= w_old_rd;
                r_taps[1][2] <= w_new_rd;
                r_taps[2][2] <= i_pixel_in;
            end
        end
    end

    assign o_taps      = r_taps;
    assign o_win_valid = r_win_valid;
    assign o_border    = r_border;

endmodule
`default_nettype wire

// File: rtl/sobel_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge_detector
// Description : Streaming 3x3 Sobel edge detector on 4-bit pixels. Three
//               register stages (taps -> Gx/Gy -> outputs); one output beat
//               per input beat, three clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_edge_detector
    import sobel_edge_detector_pkg::*;
#(
    parameter int         IMG_W  = DEF_IMG_W,
    parameter int         IMG_H  = DEF_IMG_H,
    parameter logic [6:0] THRESH = 7'(DEF_THRESH)
) (
    input  wire logic clk,
    input  wire logic rst,
    sobel_edge_detector_if.slave bus
);
    pixel_t     w_taps [3][3];
    logic       w_win_valid, w_border;
    logic [5:0] w_right, w_left, w_bot, w_top;
    grad_t      w_gx, w_gy;
    logic [6:0] w_mag;

    grad_t      r_gx, r_gy;
    logic       r_v2, r_border2;
    logic [3:0] r_edge_mag;
    logic       r_edge_bit, r_out_valid;

    sobel_edge_detector_window_3x3 #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .i_pixel_in  (bus.pixel_in),
        .i_in_valid  (bus.in_valid),
        .i_sof       (bus.sof),
        .o_taps      (w_taps),
        .o_win_valid (w_win_valid),
        .o_border    (w_border)
    );

    // Weighted (1,2,1) column and row sums; each is at most 60
    assign w_right = {2'b00, w_taps[0][2]} + {1'b0, w_taps[1][2], 1'b0} + {2'b00, w_taps[2][2]};
    assign w_left  = {2'b00, w_taps[0][0]} + {1'b0, w_taps[1][0], 1'b0} + {2'b00, w_taps[2][0]};
    assign w_bot   = {2'b00, w_taps[2][0]} + {1'b0, w_taps[2][1], 1'b0} + {2'b00, w_taps[2][2]};
    assign w_top   = {2'b00, w_taps[0][0]} + {1'b0, w_taps[0][1], 1'b0} + {2'b00, w_taps[0][2]};
    assign w_gx    = $signed({1'b0, w_right}) - $signed({1'b0, w_left});
    assign w_gy    = $signed({1'b0, w_bot})   - $signed({1'b0, w_top});

    // Stage 2: register gradients; hold while no window arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx      <= '0;
            r_gy      <= '0;
            r_border2 <= 1'b0;
            r_v2      <= 1'b0;
        end else begin
            r_v2 <= w_win_valid;
            if (w_win_valid) begin
                r_gx      <= w_gx;
                r_gy      <= w_gy;
                r_border2 <= w_border;
            end
        end
    end

    assign w_mag = abs7(r_gx) + abs7(r_gy);

    // Stage 3: magnitude, threshold and border masking; outputs hold in gaps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_mag  <= '0;
            r_edge_bit  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_edge_mag <= r_border2 ? 4'd0 : w_mag[6:3];
                r_edge_bit <= !r_border2 && (w_mag >= THRESH);
            end
        end
    end

    assign bus.edge_mag  = r_edge_mag;
    assign bus.edge_bit  = r_edge_bit;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_detector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sobel_edge_detector
// Description : Self-checking bench for sobel_edge_detector on a reduced
//               16x12 image. A frame-array reference model computes each
//               output from the pixels stored at its raster position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_detector;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int TH = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_edge_detector_if bus ();

    sobel_edge_detector #(
        .IMG_W  (W),
        .IMG_H  (H),
        .THRESH (7'(TH))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int img [H][W];
    int mr = 0, mc = 0;
    int pv1 = 0, pm1 = 0, pb1 = 0;
    int pv2 = 0, pm2 = 0, pb2 = 0;
    int last_mag = 0, last_bit = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Place a beat in the model image and compute its Sobel result
    task automatic model_beat(input int pix, input bit s, output int em, output int eb);
        int r, c, gx, gy, mag;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        img[r][c] = pix;
        em = 0;
        eb = 0;
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            em = mag / 8;
            eb = (mag >= TH) ? 1 : 0;
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    // Drive one clock of input and check the output belonging to two steps ago
    task automatic step(input bit v, input int pix, input bit s);
        int em, eb;
        em = 0;
        eb = 0;
        bus.in_valid = v;
        bus.pixel_in = 4'(pix);
        bus.sof      = s;
        if (v) model_beat(pix, s, em, eb);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(pv2));
        if (pv2 != 0) begin
            last_mag = pm2;
            last_bit = pb2;
        end
        chk("edge_mag", 32'(bus.edge_mag), 32'(last_mag));
        chk("edge_bit", 32'(bus.edge_bit), 32'(last_bit));
        pv2 = pv1; pm2 = pm1; pb2 = pb1;
        pv1 = v;   pm1 = em;  pb1 = eb;
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_edge_mag",  32'(bus.edge_mag),  32'd0);
        chk("rst_edge_bit",  32'(bus.edge_bit),  32'd0);
        pv1 = 0; pv2 = 0;
        last_mag = 0; last_bit = 0;
        mr = 0; mc = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int pat(input int kind, input int r, input int c);
        case (kind)
            0:       return 7;                                        // flat
            1:       return (c >= W/2) ? 15 : 0;                      // vertical step
            2:       return (r >= H/2) ? 15 : 0;                      // horizontal step
            3:       return (r == 5 && c == 5) ? 15 : 0;              // single bright pixel
            4:       return ((r + c) % 2 != 0) ? 15 : 0;              // 1-pixel checkerboard
            5:       return (((r / 2) + (c / 2)) % 2 != 0) ? 15 : 0;  // 2-pixel checkerboard
            default: return int'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic run_frame(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, pat(kind, r, c), (r == 0 && c == 0));
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.pixel_in = '0;
        bus.sof      = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_edge_mag",  32'(bus.edge_mag),  32'd0);
        chk("reset_edge_bit",  32'(bus.edge_bit),  32'd0);

        // Directed image patterns, one frame each
        for (int k = 0; k <= 5; k++) run_frame(k);

        // Random pixels with gaps, stray sof (with and without valid), mid-frame reset
        for (int i = 0; i < 700; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 80) == 0);
            step(v, int'($urandom_range(0, 15)), s);
            if (i == 350) do_reset();
        end

        // Gap-free random frame after everything else
        run_frame(6);

        // Drain the pipeline
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
